uart_regfile_streamer: RTL

Parametrised successor to the fixed 32x32 register-file UART transmitter. It snapshots an NREGS x XLEN register file on request and streams it as a framed 8N1 UART packet with a header, payload, end marker and XOR checksum. In delta mode it sends only registers changed since the last completed frame, each tagged with its index. It sits between the processor's register-file export and the host-facing tx pin, alongside the instruction receiver.

---
 rtl/uart_stream_pkg.sv | 26 ++
 rtl/uart_tx_byte.sv | 78 +++++++
 rtl/uart_regfile_streamer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_pkg.sv
// Shared definitions for the register-file UART streamer.
//   SOF_FULL / SOF_DELTA : header byte for full / delta frames
//   EOF_BYTE             : end-of-payload marker
//   frame_state_e        : frame sequencing states
//   bytes_per_reg()      : payload bytes per register (XLEN / 8)
package uart_stream_pkg;

  localparam logic [7:0] SOF_FULL  = 8'hA5;
  localparam logic [7:0] SOF_DELTA = 8'hA6;
  localparam logic [7:0] EOF_BYTE  = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StScan,
    StIdx,
    StData,
    StEof,
    StCsum
  } frame_state_e;

  function automatic int unsigned bytes_per_reg(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : load byte_i and begin the start bit next cycle (ignored while busy)
//   byte_i   : byte to send, LSB first
//   tx_o     : serial line, idles high
//   done_o   : one-cycle pulse during the final cycle of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  logic             busy_q, busy_d;
  logic [3:0]       bit_q, bit_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [8:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_end;

  assign baud_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign tx_o     = tx_q;

  // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_comb begin
    busy_d  = busy_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_o  = busy_q && baud_end && (bit_q == 4'd9);
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, byte_i};
        tx_d    = 1'b0;
        bit_d   = '0;
        baud_d  = '0;
      end
    end else if (baud_end) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_d = baud_q + BaudW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      bit_q   <= '0;
      baud_q  <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_regfile_streamer.sv
// Snapshots an NREGS x XLEN register file and streams it as an 8N1 UART frame:
// header, payload (full: every register; delta: changed registers tagged with
// their index), end marker, XOR checksum.
//   clk12    : clock
//   rstn     : asynchronous active-low reset
//   reg_file : flattened register file, register i at [XLEN*i +: XLEN]
//   do_write : level frame request, sampled in IDLE
//   delta    : frame mode sampled with do_write (0 full, 1 delta)
//   tx       : UART line, idles high
//   ready    : high while IDLE
module uart_regfile_streamer
  import uart_stream_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREGS        = 32,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                  clk12,
  input  logic                  rstn,
  input  logic [NREGS*XLEN-1:0] reg_file,
  input  logic                  do_write,
  input  logic                  delta,
  output logic                  tx,
  output logic                  ready
);

  localparam int unsigned Bpr  = bytes_per_reg(XLEN);
  localparam int unsigned BcW  = (Bpr > 1) ? $clog2(Bpr) : 1;
  localparam int unsigned IdxW = $clog2(NREGS + 1);

  frame_state_e          state_q, state_d;
  logic                  launch_q, launch_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BcW-1:0]        bcnt_q, bcnt_d;
  logic [7:0]            csum_q, csum_d;
  logic                  mode_q, mode_d;
  logic [NREGS*XLEN-1:0] snap_q, shadow_q;
  logic                  snap_load, shadow_load;

  logic                  start, done;
  logic [7:0]            tx_byte, data_byte;
  logic [XLEN-1:0]       cur_snap, cur_shadow;

  // Register and byte selection; idx_q == NREGS selects nothing.
  always_comb begin
    cur_snap   = '0;
    cur_shadow = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (idx_q == IdxW'(r)) begin
        cur_snap   = snap_q[XLEN*r +: XLEN];
        cur_shadow = shadow_q[XLEN*r +: XLEN];
      end
    end
    data_byte = '0;
    for (int unsigned b = 0; b < Bpr; b++) begin
      if (bcnt_q == BcW'(b)) data_byte = cur_snap[8*b +: 8];
    end
  end

  // Each byte state either launches its byte (launch_q) or waits for done.
  // SCAN launches directly so a sent register adds no extra gap cycle.
  always_comb begin
    state_d     = state_q;
    launch_d    = 1'b0;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    csum_d      = csum_q;
    mode_d      = mode_q;
    snap_load   = 1'b0;
    shadow_load = 1'b0;
    start       = 1'b0;
    tx_byte     = '0;
    unique case (state_q)
      StIdle: begin
        tx_byte = delta ? SOF_DELTA : SOF_FULL;
        if (do_write) begin
          start     = 1'b1;
          snap_load = 1'b1;
          mode_d    = delta;
          idx_d     = '0;
          bcnt_d    = '0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (done) state_d = StScan;
      end
      StScan: begin
        if (idx_q == IdxW'(NREGS)) begin
          tx_byte = EOF_BYTE;
          start   = 1'b1;
          state_d = StEof;
        end else if (!mode_q || (cur_snap != cur_shadow)) begin
          start = 1'b1;
          if (mode_q) begin
            tx_byte = 8'(idx_q);
            state_d = StIdx;
          end else begin
            tx_byte = data_byte;
            state_d = StData;
          end
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StIdx: begin
        if (done) begin
          state_d  = StData;
          launch_d = 1'b1;
        end
      end
      StData: begin
        tx_byte = data_byte;
        if (launch_q) begin
          start = 1'b1;
        end else if (done) begin
          if (bcnt_q == BcW'(Bpr - 1)) begin
            bcnt_d  = '0;
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end else begin
            bcnt_d   = bcnt_q + BcW'(1);
            launch_d = 1'b1;
          end
        end
      end
      StEof: begin
        if (done) begin
          state_d  = StCsum;
          launch_d = 1'b1;
        end
      end
      StCsum: begin
        tx_byte = csum_q;
        if (launch_q) begin
          start = 1'b1;
        end else if (done) begin
          shadow_load = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Checksum covers every byte from the header through EOF.
    if (start && (state_q != StCsum)) begin
      csum_d = (state_q == StIdle) ? tx_byte : (csum_q ^ tx_byte);
    end
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      launch_q <= 1'b0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      csum_q   <= '0;
      mode_q   <= 1'b0;
      snap_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      csum_q   <= csum_d;
      mode_q   <= mode_d;
      if (snap_load)   snap_q   <= reg_file;
      if (shadow_load) shadow_q <= snap_q;
    end
  end

  assign ready = (state_q == StIdle);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i  (clk12),
    .rst_ni (rstn),
    .start_i(start),
    .byte_i (tx_byte),
    .tx_o   (tx),
    .done_o (done)
  );

endmodule
